spi_tft_cmd_decoder: RTL and testbench

SPI_TFT_CMD_DECODER -- requirements
Module: spi_tft_cmd_decoder

---
 rtl/spi_tft_cmd_decoder.sv | 192 +++++++++++++++++++
 tb/tb_spi_tft_cmd_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tft_cmd_decoder.sv
// spi_tft_cmd_decoder
// Turns the byte stream of an SPI TFT host (CASET / RASET / RAMWR plus
// parameter and pixel bytes) into addressed RGB565 pixel writes that walk
// the current column/row window.
// Optional build: define SPI_TFT_DEC_ERR_CNT_EN to include the saturating
// protocol error counter on err_cnt_o; without it err_cnt_o is tied to 0.
module spi_tft_cmd_decoder #(
    parameter logic [15:0] SCREEN_WIDTH  = 16'd320,
    parameter logic [15:0] SCREEN_HEIGHT = 16'd240
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_dc_i,
    output logic        pix_we_o,
    output logic [15:0] pix_x_o,
    output logic [15:0] pix_y_o,
    output logic [15:0] pix_data_o,
    output logic        frame_done_o,
    output logic [7:0]  err_cnt_o
);

    localparam logic [7:0]  CMD_NOP   = 8'h00;
    localparam logic [7:0]  CMD_CASET = 8'h2A;
    localparam logic [7:0]  CMD_RASET = 8'h2B;
    localparam logic [7:0]  CMD_RAMWR = 8'h2C;
    localparam logic [15:0] X_MAX     = SCREEN_WIDTH - 16'd1;
    localparam logic [15:0] Y_MAX     = SCREEN_HEIGHT - 16'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CASET,
        S_RASET,
        S_RAMWR
    } state_t;

    state_t      state;
    logic [1:0]  idx;
    logic [15:0] sh_start;
    logic [7:0]  sh_end_hi;
    logic [15:0] xs, xe, ys, ye;
    logic [15:0] x_cur, y_cur;
    logic        phase;
    logic [7:0]  hi_byte;

    logic [15:0] dim_max;
    logic [15:0] end_full;
    logic [15:0] end_clamped;
    logic        commit_drop;
    logic        last_col;
    logic        last_row;

    // Clamp the end coordinate of a completing window command and decide whether the commit is dropped
    always_comb begin
        dim_max     = (state == S_RASET) ? Y_MAX : X_MAX;
        end_full    = {sh_end_hi, rx_data_i};
        end_clamped = (end_full > dim_max) ? dim_max : end_full;
        commit_drop = (sh_start > end_clamped);
        last_col    = (x_cur == xe);
        last_row    = (y_cur == ye);
    end

    // Command decode, window parameter collection and pixel assembly / address walk
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= S_IDLE;
            idx          <= 2'd0;
            sh_start     <= 16'd0;
            sh_end_hi    <= 8'd0;
            xs           <= 16'd0;
            xe           <= X_MAX;
            ys           <= 16'd0;
            ye           <= Y_MAX;
            x_cur        <= 16'd0;
            y_cur        <= 16'd0;
            phase        <= 1'b0;
            hi_byte      <= 8'd0;
            pix_we_o     <= 1'b0;
            pix_x_o      <= 16'd0;
            pix_y_o      <= 16'd0;
            pix_data_o   <= 16'd0;
            frame_done_o <= 1'b0;
        end else begin
            pix_we_o     <= 1'b0;
            frame_done_o <= 1'b0;
            if (rx_valid_i && !rx_dc_i) begin
                // any command throws away a half-received pixel
                phase <= 1'b0;
                case (rx_data_i)
                    CMD_NOP: ;
                    CMD_CASET: begin
                        state <= S_CASET;
                        idx   <= 2'd0;
                    end
                    CMD_RASET: begin
                        state <= S_RASET;
                        idx   <= 2'd0;
                    end
                    CMD_RAMWR: begin
                        state <= S_RAMWR;
                        x_cur <= xs;
                        y_cur <= ys;
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (rx_valid_i) begin
                case (state)
                    S_CASET, S_RASET: begin
                        idx <= idx + 2'd1;
                        case (idx)
                            2'd0: sh_start[15:8] <= rx_data_i;
                            2'd1: sh_start[7:0]  <= rx_data_i;
                            2'd2: sh_end_hi      <= rx_data_i;
                            default: begin
                                state <= S_IDLE;
                                if (!commit_drop) begin
                                    if (state == S_CASET) begin
                                        xs <= sh_start;
                                        xe <= end_clamped;
                                    end else begin
                                        ys <= sh_start;
                                        ye <= end_clamped;
                                    end
                                end
                            end
                        endcase
                    end
                    S_RAMWR: begin
                        if (!phase) begin
                            hi_byte <= rx_data_i;
                            phase   <= 1'b1;
                        end else begin
                            phase      <= 1'b0;
                            pix_we_o   <= 1'b1;
                            pix_x_o    <= x_cur;
                            pix_y_o    <= y_cur;
                            pix_data_o <= {hi_byte, rx_data_i};
                            if (!last_col) begin
                                x_cur <= x_cur + 16'd1;
                            end else begin
                                x_cur <= xs;
                                if (!last_row) begin
                                    y_cur <= y_cur + 16'd1;
                                end else begin
                                    y_cur        <= ys;
                                    frame_done_o <= 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_TFT_DEC_ERR_CNT_EN
    logic       cmd_bad;
    logic       odd_drop;
    logic       win_drop;
    logic [1:0] err_inc;
    logic [8:0] err_sum;
    logic [7:0] err_cnt;

    // Classify protocol errors seen on this byte; a bad command can also discard a pending byte
    always_comb begin
        cmd_bad  = rx_valid_i && !rx_dc_i &&
                   (rx_data_i != CMD_NOP) && (rx_data_i != CMD_CASET) &&
                   (rx_data_i != CMD_RASET) && (rx_data_i != CMD_RAMWR);
        odd_drop = rx_valid_i && !rx_dc_i && (state == S_RAMWR) && phase;
        win_drop = rx_valid_i && rx_dc_i && ((state == S_CASET) || (state == S_RASET)) &&
                   (idx == 2'd3) && commit_drop;
        err_inc  = {1'b0, cmd_bad} + {1'b0, odd_drop} + {1'b0, win_drop};
        err_sum  = {1'b0, err_cnt} + {7'd0, err_inc};
    end

    // Saturating error count
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            err_cnt <= 8'd0;
        end else begin
            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    assign err_cnt_o = err_cnt;
`else
    assign err_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_spi_tft_cmd_decoder.sv
// tb_spi_tft_cmd_decoder
// Scoreboard bench: every pixel write is predicted when its bytes are driven
// and compared against pix_we_o / pix_x_o / pix_y_o / pix_data_o / frame_done_o.
`timescale 1ns/1ps
module tb_spi_tft_cmd_decoder;

    logic        sys_clk    = 1'b0;
    logic        sys_rst    = 1'b1;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i  = 8'd0;
    logic        rx_dc_i    = 1'b0;
    logic        pix_we_o;
    logic [15:0] pix_x_o;
    logic [15:0] pix_y_o;
    logic [15:0] pix_data_o;
    logic        frame_done_o;
    logic [7:0]  err_cnt_o;

    spi_tft_cmd_decoder dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .rx_valid_i   (rx_valid_i),
        .rx_data_i    (rx_data_i),
        .rx_dc_i      (rx_dc_i),
        .pix_we_o     (pix_we_o),
        .pix_x_o      (pix_x_o),
        .pix_y_o      (pix_y_o),
        .pix_data_o   (pix_data_o),
        .frame_done_o (frame_done_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 sys_clk = ~sys_clk;

`ifdef SPI_TFT_DEC_ERR_CNT_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    int          n_chk   = 0;
    int          n_pass  = 0;
    int          exp_err = 0;
    int          done_cnt = 0;
    int          done_base;
    logic [48:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    // Output monitor: pop one prediction per pixel write
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (frame_done_o) done_cnt++;
            if (pix_we_o) begin
                if (exp_q.size() != 0)
                    chk("pixel", 64'({pix_x_o, pix_y_o, pix_data_o, frame_done_o}), 64'(exp_q.pop_front()));
                else
                    chk("pixel_unexpected", 64'({pix_x_o, pix_y_o, pix_data_o, frame_done_o}), '1);
            end else if (frame_done_o) begin
                chk("done_without_we", 64'(frame_done_o), 64'(pix_we_o));
            end
        end
    end

    task automatic send(input logic dc, input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_dc_i    = dc;
        rx_data_i  = b;
        @(posedge sys_clk);
        #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] b);
        send(1'b0, b);
    endtask

    task automatic dat(input logic [7:0] b);
        send(1'b1, b);
    endtask

    task automatic win(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
        cmd(c);
        dat(s[15:8]);
        dat(s[7:0]);
        dat(e[15:8]);
        dat(e[7:0]);
    endtask

    task automatic pixel(input logic [15:0] x, input logic [15:0] y, input logic [15:0] d, input logic done);
        exp_q.push_back({x, y, d, done});
        dat(d[15:8]);
        dat(d[7:0]);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge sys_clk);
        @(posedge sys_clk);
        #1;
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [15:0] pat(input int x, input int y);
        return 16'(x * 31 + y * 7) ^ 16'h5A5A;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_outputs", 64'({pix_we_o, pix_x_o, pix_y_o, pix_data_o, frame_done_o, err_cnt_o}), 64'd0);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;

        // first pixel after reset lands at the origin
        cmd(8'h2C);
        pixel(16'd0, 16'd0, 16'hF800, 1'b0);
        drain("first_pixel_drain");
        repeat (3) @(posedge sys_clk);
        #1;
        chk("hold_after_first", 64'({pix_we_o, pix_data_o}), 64'({1'b0, 16'hF800}));

        // full-width strip down to the bottom edge, with stray data bytes in idle
        win(8'h2A, 16'd0, 16'd319);
        win(8'h2B, 16'd200, 16'd239);
        dat(8'hAA);
        dat(8'h55);
        dat(8'h01);
        done_base = done_cnt;
        cmd(8'h2C);
        for (int y = 200; y < 240; y++)
            for (int x = 0; x < 320; x++)
                pixel(16'(x), 16'(y), pat(x, y), (x == 319) && (y == 239));
        drain("strip_drain");
        chk("strip_done_count", 64'(done_cnt - done_base), 64'd1);

        // small window wrap
        win(8'h2A, 16'd10, 16'd11);
        win(8'h2B, 16'd5, 16'd6);
        cmd(8'h2C);
        pixel(16'd10, 16'd5, 16'h1111, 1'b0);
        pixel(16'd11, 16'd5, 16'h2222, 1'b0);
        pixel(16'd10, 16'd6, 16'h3333, 1'b0);
        pixel(16'd11, 16'd6, 16'h4444, 1'b1);
        pixel(16'd10, 16'd5, 16'h5555, 1'b0);
        drain("wrap_drain");
        repeat (2) @(posedge sys_clk);
        #1;
        chk("hold_xy", 64'({pix_we_o, pix_x_o, pix_y_o, pix_data_o}), 64'({1'b0, 16'd10, 16'd5, 16'h5555}));

        // NOP between pixels keeps the write going
        pixel(16'd11, 16'd5, 16'h6666, 1'b0);
        cmd(8'h00);
        pixel(16'd10, 16'd6, 16'h7777, 1'b0);
        drain("nop_drain");

        // abort half pixel by restarting RAMWR
        cmd(8'h2C);
        dat(8'h12);
        cmd(8'h2C);
        exp_err += ERR_EN;
        pixel(16'd10, 16'd5, 16'h3456, 1'b0);
        drain("abort_drain");
        chk("abort_err", 64'(err_cnt_o), 64'(exp_err));

        // unsupported command and dropped window commit
        cmd(8'h11);
        exp_err += ERR_EN;
        @(posedge sys_clk);
        #1;
        chk("bad_cmd_err", 64'(err_cnt_o), 64'(exp_err));
        win(8'h2A, 16'h0010, 16'h0005);
        exp_err += ERR_EN;
        @(posedge sys_clk);
        #1;
        chk("drop_err", 64'(err_cnt_o), 64'(exp_err));
        cmd(8'h2C);
        pixel(16'd10, 16'd5, 16'hA001, 1'b0);
        pixel(16'd11, 16'd5, 16'hA002, 1'b0);
        pixel(16'd10, 16'd6, 16'hA003, 1'b0);
        drain("kept_window_drain");

        // end clamping on both axes
        win(8'h2A, 16'h0000, 16'h0200);
        win(8'h2B, 16'h00EF, 16'h0100);
        cmd(8'h2C);
        for (int x = 0; x < 320; x++)
            pixel(16'(x), 16'd239, pat(x, 239), x == 319);
        pixel(16'd0, 16'd239, 16'hBEEF, 1'b0);
        drain("clamp_drain");
        chk("clamp_err", 64'(err_cnt_o), 64'(exp_err));

        // saturation of the error counter
        for (int i = 0; i < 300; i++) cmd(8'hFF);
        exp_err = (exp_err + 300 * ERR_EN > 255) ? 255 : exp_err + 300 * ERR_EN;
        @(posedge sys_clk);
        #1;
        chk("err_saturate", 64'(err_cnt_o), 64'(exp_err));

        // reset in the middle of a frame
        win(8'h2B, 16'd0, 16'd239);
        cmd(8'h2C);
        for (int i = 0; i < 100; i++) pixel(16'(i), 16'd0, pat(i, 0), 1'b0);
        drain("pre_reset_drain");
        chk("pre_reset_x", 64'(pix_x_o), 64'd99);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("async_reset_outputs", 64'({pix_we_o, pix_x_o, pix_y_o, pix_data_o, frame_done_o, err_cnt_o}), 64'd0);
        exp_err = 0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        cmd(8'h2C);
        pixel(16'd0, 16'd0, 16'hC0DE, 1'b0);
        pixel(16'd1, 16'd0, 16'hC0DF, 1'b0);
        drain("post_reset_drain");
        chk("post_reset_err", 64'(err_cnt_o), 64'(exp_err));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
